// File: rtl/i2c_master_ctrl.sv
// I2C master: register-mapped byte sequencer with prescaled SCL,
// repeated START, clock stretching and arbitration-loss detection.
module i2c_master_ctrl #(
    parameter int PRESCALE_W       = 16,
    parameter int DEFAULT_PRESCALE = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    input  logic        scl_i,
    output logic        scl_oe,
    input  logic        sda_i,
    output logic        sda_oe
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WR_BIT, S_ACK_RX, S_RD_BIT, S_ACK_TX, S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [2:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d, pre_q, pre_d;
    logic [7:0]            tx_q, tx_d, rx_q, rx_d, sh_q, sh_d;
    logic ien_q, ien_d, nack_q, nack_d;
    logic pwr_q, pwr_d, prd_q, prd_d, pstop_q, pstop_d;
    logic busy_q, busy_d, rxnack_q, rxnack_d, arb_q, arb_d;
    logic cerr_q, cerr_d, done_q, done_d, own_q, own_d;
    logic [2:0] idx;
    logic data_st, hold, tick, fin, post, arb;
    logic unused_ok;

    assign idx     = addr_i[4:2];
    assign data_st = (state_q == S_WR_BIT) || (state_q == S_ACK_RX) ||
                     (state_q == S_RD_BIT) || (state_q == S_ACK_TX);
    // stretch: quarter counter stays in reload until the slave lets SCL go
    assign hold    = data_st && (phase_q == 2'd2) && !scl_i;
    assign tick    = (state_q != S_IDLE) && !hold && (cnt_q == '0);
    assign irq_o   = ien_q & done_q;
    assign unused_ok = ^{addr_i[31:5], addr_i[1:0], data_i[31:9]};

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state_q)
            S_IDLE:   scl_oe = own_q;
            S_START:  begin
                scl_oe = phase_q[1];
                sda_oe = |phase_q;
            end
            S_WR_BIT: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = ~sh_q[7];
            end
            S_ACK_RX, S_RD_BIT: scl_oe = (phase_q == 2'd0);
            S_ACK_TX: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = ~nack_q;
            end
            S_STOP:   begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = ~phase_q[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        data_o = '0;
        case (idx)
            3'd0: data_o[8] = ien_q;
            3'd1: data_o[5:0] = {own_q, done_q, cerr_q,
                                 arb_q, rxnack_q, busy_q};
            3'd2: data_o[7:0] = tx_q;
            3'd3: data_o[7:0] = rx_q;
            3'd4: data_o[PRESCALE_W-1:0] = pre_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        pre_d    = pre_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sh_d     = sh_q;
        ien_d    = ien_q;
        nack_d   = nack_q;
        pwr_d    = pwr_q;
        prd_d    = prd_q;
        pstop_d  = pstop_q;
        busy_d   = busy_q;
        rxnack_d = rxnack_q;
        arb_d    = arb_q;
        cerr_d   = cerr_q;
        done_d   = done_q;
        own_d    = own_q;
        fin      = 1'b0;
        post     = 1'b0;
        arb      = 1'b0;
        cnt_d    = (state_q == S_IDLE || hold || cnt_q == '0)
                   ? pre_q : cnt_q - PRESCALE_W'(1);
        if (tick) phase_d = phase_q + 2'd1;

        if (we_i) begin
            case (idx)
                3'd0: begin
                    ien_d = data_i[8];
                    if (|data_i[3:0]) begin
                        if (busy_q || (data_i[2] && data_i[3])) begin
                            cerr_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            nack_d  = data_i[4];
                            pstop_d = data_i[1];
                            pwr_d   = data_i[2];
                            prd_d   = data_i[3];
                            if (data_i[0])      state_d = S_START;
                            else if (data_i[2]) state_d = S_WR_BIT;
                            else if (data_i[3]) state_d = S_RD_BIT;
                            else                state_d = S_STOP;
                        end
                    end
                end
                3'd1: begin
                    rxnack_d = rxnack_q & ~data_i[1];
                    arb_d    = arb_q & ~data_i[2];
                    cerr_d   = cerr_q & ~data_i[3];
                    done_d   = done_q & ~data_i[4];
                end
                3'd2: tx_d = data_i[7:0];
                3'd4: if (!busy_q) pre_d = data_i[PRESCALE_W-1:0];
                default: ;
            endcase
        end

        arb = tick && (phase_q == 2'd2) && !sda_oe && !sda_i &&
              (state_q == S_START || state_q == S_WR_BIT);

        if (tick) begin
            unique case (state_q)
                S_START: if (phase_q == 2'd3) begin
                    own_d = 1'b1;
                    if (pwr_q)        state_d = S_WR_BIT;
                    else if (prd_q)   state_d = S_RD_BIT;
                    else if (pstop_q) state_d = S_STOP;
                    else              fin = 1'b1;
                end
                S_WR_BIT: if (phase_q == 2'd3) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_ACK_RX;
                end
                S_ACK_RX: begin
                    if (phase_q == 2'd2) rxnack_d = sda_i;
                    if (phase_q == 2'd3) post = 1'b1;
                end
                S_RD_BIT: begin
                    if (phase_q == 2'd2) sh_d = {sh_q[6:0], sda_i};
                    if (phase_q == 2'd3) begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) begin
                            rx_d    = sh_q;
                            state_d = S_ACK_TX;
                        end
                    end
                end
                S_ACK_TX: if (phase_q == 2'd3) post = 1'b1;
                S_STOP: if (phase_q == 2'd3) begin
                    own_d = 1'b0;
                    fin   = 1'b1;
                end
                default: ;
            endcase
        end

        // a slave NACK still falls through to a pending STOP
        if (post) begin
            if (pstop_q) state_d = S_STOP;
            else         fin = 1'b1;
        end
        if (state_d == S_WR_BIT && state_q != S_WR_BIT) begin
            sh_d  = tx_q;
            bit_d = 3'd7;
        end
        if (state_d == S_RD_BIT && state_q != S_RD_BIT) bit_d = 3'd7;
        if (arb) begin
            arb_d = 1'b1;
            own_d = 1'b0;
            fin   = 1'b1;
        end
        if (fin) begin
            state_d = S_IDLE;
            phase_d = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pwr_d   = 1'b0;
            prd_d   = 1'b0;
            pstop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            bit_q    <= 3'd0;
            cnt_q    <= '0;
            pre_q    <= PRESCALE_W'(DEFAULT_PRESCALE);
            tx_q     <= '0;
            rx_q     <= '0;
            sh_q     <= '0;
            ien_q    <= 1'b0;
            nack_q   <= 1'b0;
            pwr_q    <= 1'b0;
            prd_q    <= 1'b0;
            pstop_q  <= 1'b0;
            busy_q   <= 1'b0;
            rxnack_q <= 1'b0;
            arb_q    <= 1'b0;
            cerr_q   <= 1'b0;
            done_q   <= 1'b0;
            own_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sh_q     <= sh_d;
            ien_q    <= ien_d;
            nack_q   <= nack_d;
            pwr_q    <= pwr_d;
            prd_q    <= prd_d;
            pstop_q  <= pstop_d;
            busy_q   <= busy_d;
            rxnack_q <= rxnack_d;
            arb_q    <= arb_d;
            cerr_q   <= cerr_d;
            done_q   <= done_d;
            own_q    <= own_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: scripted open-drain slave plus a
// bit-level scoreboard checked on every SCL rising edge.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        irq_o, scl_oe, sda_oe;
    logic        sl_scl = 1'b0;
    logic        sl_sda = 1'b0;
    logic        scl_bus, sda_bus;

    typedef struct packed {
        logic       v;
        logic [7:0] per;
    } exp_t;

    exp_t exp_q[$];
    bit   sl_q[$];
    exp_t m_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   stop_cnt = 0;
    int   fall_n = 0;
    int   stretch_at = -1;
    time  last_rise = 0;

    assign scl_bus = ~(scl_oe | sl_scl);
    assign sda_bus = ~(sda_oe | sl_sda);

    i2c_master_ctrl #(.PRESCALE_W(16), .DEFAULT_PRESCALE(100)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
        .scl_i(scl_bus), .scl_oe(scl_oe),
        .sda_i(sda_bus), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge scl_bus) begin
        fall_n++;
        sl_sda = (sl_q.size() != 0) ? !sl_q.pop_front() : 1'b0;
        if (fall_n == stretch_at) begin
            sl_scl = 1'b1;
            repeat (22) @(posedge clk);
            #1 sl_scl = 1'b0;
        end
    end

    always @(posedge scl_bus) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            chk("sda_bit", 32'(sda_bus), 32'(m_e.v));
            if (m_e.per != 0)
                chk("bit_clks", 32'(($time - last_rise + 5) / 10),
                    32'(m_e.per));
        end
        last_rise = $time;
    end

    always @(posedge sda_bus) begin
        #1;
        if (scl_bus && sda_bus) stop_cnt++;
    end

    task automatic wr(input int idx, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1;
        addr_i = 32'(idx) << 2;
        data_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        addr_i = 32'(idx) << 2;
        #1 d = data_o;
    endtask

    task automatic exp_bit(input logic v, input int per);
        exp_t e;
        e.v = v;
        e.per = 8'(per);
        exp_q.push_back(e);
    endtask

    task automatic exp_byte(input logic [7:0] b, input int p0);
        for (int i = 7; i >= 0; i--) exp_bit(b[i], (i == 7) ? p0 : 8);
    endtask

    task automatic sl_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sl_q.push_back(b[i]);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        st = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rd(1, st);
            if (st[4]) break;
        end
        chk(tag, 32'(st[4]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [31:0] rst_val [8];
        int          s0;
        rst_val = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd100,
                    32'd0, 32'd0, 32'd0};
        #3 rst = 1'b0;
        #1 chk("rst_lines", {29'd0, scl_oe, sda_oe, irq_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(i, r);
            chk($sformatf("rst_reg%0d", i), r, rst_val[i]);
        end

        wr(4, 32'd1);
        wr(2, 32'hA4);
        sl_byte(8'hFF);
        sl_q.push_back(1'b0);
        sl_byte(8'h5A);
        sl_q.push_back(1'b1);
        exp_byte(8'hA4, 0);
        exp_bit(1'b0, 8);
        exp_byte(8'h5A, 0);
        exp_bit(1'b1, 8);
        wr(0, 32'h105);
        wait_done("t2_done");
        rd(1, r);
        chk("t2_status", r, 32'h30);
        chk("t2_irq", 32'(irq_o), 32'd1);
        wr(1, 32'h10);
        #1 chk("t2_irq_clr", 32'(irq_o), 32'd0);

        s0 = stop_cnt;
        wr(0, 32'h1A);
        wait_done("t3_done");
        rd(3, r);
        chk("t3_rxdata", r, 32'h5A);
        rd(1, r);
        chk("t3_status", r, 32'h10);
        #20 chk("t3_stop", 32'(stop_cnt - s0), 32'd1);
        chk("t3_irq", 32'(irq_o), 32'd0);
        wr(1, 32'h10);

        s0 = stop_cnt;
        wr(2, 32'h55);
        exp_byte(8'h55, 0);
        exp_bit(1'b1, 8);
        wr(0, 32'h07);
        wait_done("t4_done");
        rd(1, r);
        chk("t4_status", r, 32'h12);
        #20 chk("t4_stop", 32'(stop_cnt - s0), 32'd1);
        wr(1, 32'h12);

        wr(2, 32'h3C);
        sl_byte(8'hFF);
        sl_q.push_back(1'b0);
        for (int i = 7; i >= 0; i--)
            exp_bit(1'(8'h3C >> i),
                    (i == 7) ? 0 : (i == 3) ? 28 : (i == 2) ? 0 : 8);
        exp_bit(1'b0, 8);
        stretch_at = fall_n + 5;
        wr(0, 32'h07);
        wait_done("t5_done");
        rd(1, r);
        chk("t5_status", r, 32'h10);
        wr(1, 32'h10);

        wr(2, 32'hA4);
        repeat (5) sl_q.push_back(1'b1);
        sl_q.push_back(1'b0);
        for (int i = 7; i >= 2; i--)
            exp_bit((i == 2) ? 1'b0 : 1'(8'hA4 >> i), (i == 7) ? 0 : 8);
        wr(0, 32'h07);
        wr(0, 32'h101);
        wr(4, 32'd7);
        r = 32'd1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rd(1, r);
            if (!r[0]) break;
        end
        chk("t6_busy", 32'(r[0]), 32'd0);
        chk("t6_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
        chk("t6_status", r, 32'h1C);
        chk("t6_irq", 32'(irq_o), 32'd1);
        rd(4, r);
        chk("t6_prescale", r, 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        wr(1, 32'h1C);
        wr(0, 32'h01);
        repeat (5) @(negedge clk);
        chk("t7_driving", {30'd0, scl_oe, sda_oe}, 32'd3);
        rst = 1'b0;
        #1 chk("t7_rst_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
        rd(4, r);
        chk("t7_prescale", r, 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
